// File: rtl/seq_gen_serializer.sv
// seq_gen_serializer
//   Serial pattern generator. Accepts a WIDTH-bit pattern over a
//   valid/ready handshake and shifts it out MSB-first, holding each bit
//   for BIT_CYCLES clocks. A one-cycle done pulse follows the last bit of
//   every frame. eq_pair flags that the current bit repeats the previous
//   bit of the same frame.
//
// Parameters
//   WIDTH       pattern width in bits (>= 2)
//   BIT_CYCLES  clocks each serial bit is held (>= 1)
//
// Ports
//   clock       rising-edge clock
//   reset       asynchronous, active-high reset
//   D_in        pattern word, sampled on handshake
//   load_valid  upstream has a pattern on D_in
//   load_ready  block can accept a pattern (combinational)
//   D_out       serial bit (registered)
//   bit_valid   D_out carries a frame bit (registered)
//   eq_pair     current bit equals previous bit of the frame (registered)
//   done        one-cycle pulse after the last bit of a frame (registered)
module seq_gen_serializer #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] D_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             D_out,
  output logic             bit_valid,
  output logic             eq_pair,
  output logic             done
);

  localparam int BIT_W = $clog2(WIDTH);
  localparam int DIV_W = ($clog2(BIT_CYCLES) > 1) ? $clog2(BIT_CYCLES) : 1;

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   shreg_q;
  logic [BIT_W-1:0]   bit_cnt_q;
  logic [DIV_W-1:0]   div_cnt_q;
  logic               d_out_q;
  logic               bit_valid_q;
  logic               eq_pair_q;
  logic               done_q;

  // Bit that becomes the MSB after the next shift, and whether it repeats
  // the bit currently on the line.
  logic               next_bit_d;
  logic               next_eq_d;

  assign next_bit_d = shreg_q[WIDTH-2];
  assign next_eq_d  = (shreg_q[WIDTH-2] == shreg_q[WIDTH-1]);

  // Ready drops as soon as reset rises so a handshake in a reset cycle is
  // never considered accepted upstream.
  assign load_ready = (state_q == IDLE) && !reset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      div_cnt_q   <= '0;
      d_out_q     <= 1'b0;
      bit_valid_q <= 1'b0;
      eq_pair_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (load_valid && load_ready) begin
            // Present the MSB right away so the first bit appears in the
            // cycle after the handshake.
            shreg_q     <= D_in;
            bit_cnt_q   <= '0;
            div_cnt_q   <= '0;
            d_out_q     <= D_in[WIDTH-1];
            bit_valid_q <= 1'b1;
            eq_pair_q   <= 1'b0;
            state_q     <= SHIFT;
          end
        end

        SHIFT: begin
          if (div_cnt_q == DIV_LAST) begin
            div_cnt_q <= '0;
            if (bit_cnt_q == BIT_LAST) begin
              state_q     <= DONE;
              done_q      <= 1'b1;
              bit_valid_q <= 1'b0;
              d_out_q     <= 1'b0;
              eq_pair_q   <= 1'b0;
            end else begin
              shreg_q   <= shreg_q << 1;
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
              d_out_q   <= next_bit_d;
              eq_pair_q <= next_eq_d;
            end
          end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign D_out     = d_out_q;
  assign bit_valid = bit_valid_q;
  assign eq_pair   = eq_pair_q;
  assign done      = done_q;

endmodule

// File: tb/tb_seq_gen_serializer.sv
// Bench for seq_gen_serializer: one instance with BIT_CYCLES=1 and one with
// BIT_CYCLES=3, both WIDTH=8. Expected {D_out, eq_pair} pairs are pushed to
// a per-instance queue when a pattern is offered and popped per valid cycle.
module tb_seq_gen_serializer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;

  logic [7:0] d_in1 = '0;
  logic       lv1 = 1'b0;
  logic       lr1, dout1, bv1, eq1, done1;

  logic [7:0] d_in3 = '0;
  logic       lv3 = 1'b0;
  logic       lr3, dout3, bv3, eq3, done3;

  int n_chk  = 0;
  int n_fail = 0;

  logic [1:0] q1[$];
  logic [1:0] q3[$];

  always #5 clock = ~clock;

  seq_gen_serializer #(.WIDTH(8), .BIT_CYCLES(1)) dut1 (
    .clock(clock), .reset(reset), .D_in(d_in1), .load_valid(lv1),
    .load_ready(lr1), .D_out(dout1), .bit_valid(bv1), .eq_pair(eq1),
    .done(done1)
  );

  seq_gen_serializer #(.WIDTH(8), .BIT_CYCLES(3)) dut3 (
    .clock(clock), .reset(reset), .D_in(d_in3), .load_valid(lv3),
    .load_ready(lr3), .D_out(dout3), .bit_valid(bv3), .eq_pair(eq3),
    .done(done3)
  );

  // Reference model: MSB-first bits, eq_pair 0 on the first bit.
  function automatic void push_frame(input bit three, input logic [7:0] p);
    logic [1:0] e;
    for (int k = 0; k < 8; k++) begin
      e[1] = p[7-k];
      e[0] = (k == 0) ? 1'b0 : (p[7-k] == p[(8-k) % 8]);
      for (int r = 0; r < (three ? 3 : 1); r++) begin
        if (three) q3.push_back(e);
        else       q1.push_back(e);
      end
    end
  endfunction

  task automatic test_reset();
    logic [1:0] e;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_chk++;
    if ({lr1, dout1, bv1, eq1, done1} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_state1: got lr/d/bv/eq/done=%b required 00000", {lr1, dout1, bv1, eq1, done1});
    end
    n_chk++;
    if ({lr3, dout3, bv3, eq3, done3} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_state3: got lr/d/bv/eq/done=%b required 00000", {lr3, dout3, bv3, eq3, done3});
    end
    // Handshake offered while reset is high is not accepted.
    lv1 = 1'b1; d_in1 = 8'h81;
    @(negedge clock);
    n_chk++;
    if ({lr1, bv1} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_handshake: got lr/bv=%b required 00", {lr1, bv1});
    end
    // Release: ready in the very first cycle, handshake there is legal.
    reset = 1'b0;
    push_frame(1'b0, 8'h81);
    #1;
    n_chk++;
    if (lr1 !== 1'b1) begin
      n_fail++;
      $display("FAIL release_ready: got %b required 1", lr1);
    end
    @(negedge clock);
    lv1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      e = q1.pop_front();
      n_chk++;
      if ({bv1, dout1, eq1} !== {1'b1, e}) begin
        n_fail++;
        $display("FAIL release_frame bit%0d: got bv/d/eq=%b required %b", i, {bv1, dout1, eq1}, {1'b1, e});
      end
      @(negedge clock);
    end
    n_chk++;
    if ({done1, bv1, dout1, eq1} !== 4'b1000) begin
      n_fail++;
      $display("FAIL release_done: got done/bv/d/eq=%b required 1000", {done1, bv1, dout1, eq1});
    end
    @(negedge clock);
  endtask

  task automatic test_basic();
    logic [1:0] e;
    lv1 = 1'b1; d_in1 = 8'b1011_0011;
    push_frame(1'b0, 8'b1011_0011);
    n_chk++;
    if (lr1 !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_ready: got %b required 1", lr1);
    end
    @(negedge clock);
    lv1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      e = q1.pop_front();
      n_chk++;
      if ({bv1, dout1, eq1, lr1} !== {1'b1, e, 1'b0}) begin
        n_fail++;
        $display("FAIL basic bit%0d: got bv/d/eq/lr=%b required %b", i, {bv1, dout1, eq1, lr1}, {1'b1, e, 1'b0});
      end
      @(negedge clock);
    end
    n_chk++;
    if ({done1, bv1, dout1, eq1, lr1} !== 5'b10000) begin
      n_fail++;
      $display("FAIL basic_done: got done/bv/d/eq/lr=%b required 10000", {done1, bv1, dout1, eq1, lr1});
    end
    @(negedge clock);
    n_chk++;
    if ({lr1, done1, bv1} !== 3'b100) begin
      n_fail++;
      $display("FAIL basic_idle: got lr/done/bv=%b required 100", {lr1, done1, bv1});
    end
  endtask

  task automatic test_bit_cycles();
    logic [1:0] e;
    lv3 = 1'b1; d_in3 = 8'hA5;
    push_frame(1'b1, 8'hA5);
    @(negedge clock);
    lv3 = 1'b0;
    for (int i = 0; i < 24; i++) begin
      e = q3.pop_front();
      n_chk++;
      if ({bv3, dout3, eq3, done3} !== {1'b1, e, 1'b0}) begin
        n_fail++;
        $display("FAIL hold3 cyc%0d: got bv/d/eq/done=%b required %b", i, {bv3, dout3, eq3, done3}, {1'b1, e, 1'b0});
      end
      @(negedge clock);
    end
    n_chk++;
    if ({done3, bv3, dout3} !== 3'b100) begin
      n_fail++;
      $display("FAIL hold3_done: got done/bv/d=%b required 100", {done3, bv3, dout3});
    end
    @(negedge clock);
    n_chk++;
    if ({lr3, done3} !== 2'b10) begin
      n_fail++;
      $display("FAIL hold3_idle: got lr/done=%b required 10", {lr3, done3});
    end
  endtask

  task automatic test_ignored_load();
    logic [1:0] e;
    lv1 = 1'b1; d_in1 = 8'hF0;
    push_frame(1'b0, 8'hF0);
    @(negedge clock);
    lv1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      e = q1.pop_front();
      n_chk++;
      if ({bv1, dout1, eq1} !== {1'b1, e}) begin
        n_fail++;
        $display("FAIL ignored bit%0d: got bv/d/eq=%b required %b", i, {bv1, dout1, eq1}, {1'b1, e});
      end
      if (i == 2) begin
        n_chk++;
        if (lr1 !== 1'b0) begin
          n_fail++;
          $display("FAIL ignored_ready: got %b required 0", lr1);
        end
      end
      // One-cycle pulse mid-frame, later raised again and held.
      lv1 = (i == 2) || (i >= 5);
      d_in1 = (i == 2 || i >= 5) ? 8'h3C : 8'h00;
      @(negedge clock);
    end
    n_chk++;
    if ({done1, bv1, lr1} !== 3'b100) begin
      n_fail++;
      $display("FAIL ignored_done: got done/bv/lr=%b required 100", {done1, bv1, lr1});
    end
    @(negedge clock);
    push_frame(1'b0, 8'h3C);
    n_chk++;
    if ({lr1, bv1} !== 2'b10) begin
      n_fail++;
      $display("FAIL ignored_idle: got lr/bv=%b required 10", {lr1, bv1});
    end
    @(negedge clock);
    lv1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      e = q1.pop_front();
      n_chk++;
      if ({bv1, dout1, eq1} !== {1'b1, e}) begin
        n_fail++;
        $display("FAIL held_load bit%0d: got bv/d/eq=%b required %b", i, {bv1, dout1, eq1}, {1'b1, e});
      end
      @(negedge clock);
    end
    n_chk++;
    if (done1 !== 1'b1) begin
      n_fail++;
      $display("FAIL held_load_done: got %b required 1", done1);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_midframe();
    logic [1:0] e;
    lv1 = 1'b1; d_in1 = 8'hD8;
    push_frame(1'b0, 8'hD8);
    @(negedge clock);
    lv1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      e = q1.pop_front();
      n_chk++;
      if ({bv1, dout1, eq1} !== {1'b1, e}) begin
        n_fail++;
        $display("FAIL midreset bit%0d: got bv/d/eq=%b required %b", i, {bv1, dout1, eq1}, {1'b1, e});
      end
      if (i < 4) @(negedge clock);
    end
    // Bit 4 is 1 with eq_pair 1, so each output visibly falls.
    #2 reset = 1'b1;
    #1;
    q1.delete();
    n_chk++;
    if ({dout1, bv1, eq1, lr1, done1} !== 5'b0) begin
      n_fail++;
      $display("FAIL midreset_async: got d/bv/eq/lr/done=%b required 00000", {dout1, bv1, eq1, lr1, done1});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_chk++;
      if ({done1, bv1} !== 2'b00) begin
        n_fail++;
        $display("FAIL midreset_hold%0d: got done/bv=%b required 00", i, {done1, bv1});
      end
    end
    reset = 1'b0;
    #1;
    n_chk++;
    if (lr1 !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_release: got lr=%b required 1", lr1);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_chk++;
      if ({done1, bv1, lr1} !== 3'b001) begin
        n_fail++;
        $display("FAIL midreset_after%0d: got done/bv/lr=%b required 001", i, {done1, bv1, lr1});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] e;
    int gap;
    int dones;
    lv1 = 1'b1; d_in1 = 8'hFF;
    push_frame(1'b0, 8'hFF);
    @(negedge clock);
    d_in1 = 8'h00;
    gap = 0;
    dones = 0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) begin
        e = q1.pop_front();
        n_chk++;
        if ({bv1, dout1, eq1} !== {1'b1, e}) begin
          n_fail++;
          $display("FAIL b2b f%0d bit%0d: got bv/d/eq=%b required %b", f, i, {bv1, dout1, eq1}, {1'b1, e});
        end
        @(negedge clock);
      end
      if (done1 === 1'b1) dones++;
      if (bv1 === 1'b0) gap++;
      @(negedge clock);
      if (bv1 === 1'b0) gap++;
      if (f == 0) push_frame(1'b0, 8'h00);
      @(negedge clock);
      lv1 = 1'b0;
      if (f == 0) begin
        n_chk++;
        if (gap !== 2) begin
          n_fail++;
          $display("FAIL b2b_gap: got %0d low cycles required 2", gap);
        end
      end
    end
    n_chk++;
    if (dones !== 2) begin
      n_fail++;
      $display("FAIL b2b_dones: got %0d done pulses required 2", dones);
    end
    n_chk++;
    if (q1.size() + q3.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %0d left required 0", q1.size() + q3.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bit_cycles();
    test_ignored_load();
    test_reset_midframe();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got no completion required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_gen_serializer.md
# seq_gen_serializer

Serial pattern generator that drives the single-bit stream consumed by the team's sequence-recognizer blocks. It accepts a WIDTH-bit pattern word over a valid/ready handshake and shifts it out MSB-first on D_out, holding each bit for BIT_CYCLES clocks. A frame-done pulse marks the end of each frame. An eq_pair reference flag lets benches cross-check recognizer output bit-for-bit.

## Interface
- WIDTH, 8: pattern word width in bits; legal range is WIDTH >= 2.
- BIT_CYCLES, 1: clocks each serial bit is held; legal range is BIT_CYCLES >= 1.

- clock  input  1  rising-edge clock; the only clock.
- reset  input  1  asynchronous, active-high reset.
- D_in  input  WIDTH  pattern word; sampled on handshake.
- load_valid  input  1  upstream asserts when D_in holds a pattern.
- load_ready  output  1  block can accept a pattern this cycle.
- D_out  output  1  serial bit, registered.
- bit_valid  output  1  D_out carries a frame bit, registered.
- eq_pair  output  1  current bit equals previous bit of the same frame, registered.
- done  output  1  one-cycle pulse after the last bit of a frame, registered.

## Operation
- States:
  - IDLE:
    - load_ready = 1.
    - On load_valid && load_ready, capture D_in into the shift register.
    - Clear bit_cnt and div_cnt, then go to SHIFT.
  - SHIFT:
    - D_out = shreg[WIDTH-1]; bit_valid = 1.
    - div_cnt counts 0..BIT_CYCLES-1.
    - At div_cnt terminal with bit_cnt == WIDTH-1: go to DONE.
    - At div_cnt terminal otherwise: shift left by 1, bit_cnt++, div_cnt = 0.
  - DONE:
    - Lasts exactly one cycle.
    - done = 1, bit_valid = 0, D_out = 0.
    - Next state is IDLE.
- load_ready = (state == IDLE) && !reset. It is a combinational decode and is the only unregistered output.
- load_valid outside IDLE is ignored and D_in is not sampled. Upstream must hold load_valid and D_in stable until load_ready.
- eq_pair:
  - 0 on the first bit of every frame.
  - For bit k >= 1, eq_pair = (bit k == bit k-1). Value is constant across that bit's BIT_CYCLES clocks.
  - 0 in IDLE and DONE.
- Counter widths: bit_cnt is $clog2(WIDTH) bits; div_cnt is max(1, $clog2(BIT_CYCLES)) bits. No wrap occurs within a frame.
- Reset:
  - Asynchronous: state goes to IDLE immediately.
  - D_out, bit_valid, eq_pair, done, shreg and counters all go to 0.
  - load_ready reads 0 while reset is high.
- Reset mid-frame aborts the frame. No done is produced and the partial pattern is discarded.

## Timing
- Handshake accepted at edge E (end of cycle t): first bit on D_out with bit_valid in cycle t+1.
- Frame occupies WIDTH*BIT_CYCLES consecutive bit_valid cycles.
- done is high in cycle t+1+WIDTH*BIT_CYCLES.
- load_ready returns in the following cycle.
- Back-to-back frames: exactly 2 non-valid cycles (DONE, IDLE) between the last bit of one frame and the first bit of the next.
- Reset release: load_ready = 1 in the first cycle with reset low. A handshake in that cycle is legal.
- Reset asserted in the same cycle as a handshake: the handshake is lost and load_ready = 0.

## Test plan
- Pattern 8'b1011_0011, WIDTH=8, BIT_CYCLES=1, accepted at cycle t. Required response:
  - D_out = 1,0,1,1,0,0,1,1 in cycles t+1..t+8; bit_valid high for those 8 cycles.
  - eq_pair = 0,0,0,1,0,1,0,1.
  - done = 1 at t+9; load_ready = 1 at t+10.
- Pattern 8'hA5, BIT_CYCLES=3. Required response:
  - Each bit held 3 cycles; bit_valid high for 24 cycles.
  - Bit sequence 1,0,1,0,0,1,0,1.
  - done at t+25.
- Ignored load: load_valid pulsed for 1 cycle with 8'h3C during SHIFT of a 8'hF0 frame. Required response:
  - Output is the 8'hF0 bit sequence unchanged; 8'h3C never appears.
  - The same load_valid held high is accepted in the first IDLE cycle.
- Reset mid-frame: reset asserted mid-cycle during bit 4. Required response:
  - D_out, bit_valid, eq_pair and load_ready go to 0 before the next edge.
  - No done pulse.
  - load_ready = 1 in the first cycle after release.
- Back-to-back: load_valid held high with 8'hFF, then 8'h00. Required response:
  - eq_pair = 0,1,1,1,1,1,1,1 in both frames.
  - Exactly 2 bit_valid-low cycles between the frames.
  - One done pulse per frame.
